// File: rtl/cp0_reg_pkg.sv
// CP0 register numbers, exception codes, reset constants and the decode of
// the MEM-stage excepttype into the action CP0 has to take.
package cp0_reg_pkg;

    localparam logic [4:0] CP0_REG_COUNT   = 5'd9;
    localparam logic [4:0] CP0_REG_COMPARE = 5'd11;
    localparam logic [4:0] CP0_REG_STATUS  = 5'd12;
    localparam logic [4:0] CP0_REG_CAUSE   = 5'd13;
    localparam logic [4:0] CP0_REG_EPC     = 5'd14;
    localparam logic [4:0] CP0_REG_PRID    = 5'd15;
    localparam logic [4:0] CP0_REG_CONFIG  = 5'd16;

    localparam logic [31:0] EXC_INTERRUPT = 32'h0000_0001;
    localparam logic [31:0] EXC_SYSCALL   = 32'h0000_0008;
    localparam logic [31:0] EXC_INST_INV  = 32'h0000_000a;
    localparam logic [31:0] EXC_TRAP      = 32'h0000_000d;
    localparam logic [31:0] EXC_OVERFLOW  = 32'h0000_000c;
    localparam logic [31:0] EXC_ERET      = 32'h0000_000e;

    localparam logic [4:0] EXCCODE_INT  = 5'd0;
    localparam logic [4:0] EXCCODE_SYS  = 5'd8;
    localparam logic [4:0] EXCCODE_RI   = 5'd10;
    localparam logic [4:0] EXCCODE_OV   = 5'd12;
    localparam logic [4:0] EXCCODE_TR   = 5'd13;

    localparam logic [31:0] STATUS_RST = 32'h1000_0000;
    localparam logic [31:0] CAUSE_RST  = 32'h0000_0000;

    // What an excepttype does to Status/Cause/EPC
    typedef enum logic [2:0] {
        EXC_K_NONE,   // no exception: software writes proceed
        EXC_K_INT,    // interrupt: EPC/BD always recorded
        EXC_K_SYNC,   // synchronous exception: EPC/BD only when EXL=0
        EXC_K_ERET,   // return: clear EXL
        EXC_K_OTHER   // unknown nonzero code: nothing changes
    } exc_kind_e;

    typedef struct packed {
        exc_kind_e  kind;
        logic [4:0] exccode;
    } exc_dec_t;

    function automatic exc_dec_t exc_decode(input logic [31:0] excepttype);
        exc_dec_t d;
        d.kind    = EXC_K_OTHER;
        d.exccode = EXCCODE_INT;
        case (excepttype)
            32'h0:         d.kind = EXC_K_NONE;
            EXC_INTERRUPT: begin d.kind = EXC_K_INT;  d.exccode = EXCCODE_INT; end
            EXC_SYSCALL:   begin d.kind = EXC_K_SYNC; d.exccode = EXCCODE_SYS; end
            EXC_INST_INV:  begin d.kind = EXC_K_SYNC; d.exccode = EXCCODE_RI;  end
            EXC_TRAP:      begin d.kind = EXC_K_SYNC; d.exccode = EXCCODE_TR;  end
            EXC_OVERFLOW:  begin d.kind = EXC_K_SYNC; d.exccode = EXCCODE_OV;  end
            EXC_ERET:      d.kind = EXC_K_ERET;
            default:       d.kind = EXC_K_OTHER;
        endcase
        return d;
    endfunction

endpackage

// File: rtl/cp0_reg_if.sv
// MTC0/MFC0 access and MEM-stage exception report into CP0.
interface cp0_reg_if;
    logic        we_i;
    logic [4:0]  waddr_i;
    logic [31:0] data_i;
    logic [4:0]  raddr_i;
    logic [31:0] data_o;
    logic [31:0] excepttype_i;
    logic [31:0] current_inst_addr_i;
    logic        is_in_delayslot_i;

    modport master (
        output we_i, waddr_i, data_i, raddr_i,
               excepttype_i, current_inst_addr_i, is_in_delayslot_i,
        input  data_o
    );

    modport slave (
        input  we_i, waddr_i, data_i, raddr_i,
               excepttype_i, current_inst_addr_i, is_in_delayslot_i,
        output data_o
    );
endinterface

// File: rtl/cp0_reg_timer.sv
// Count/Compare pair and the sticky timer interrupt.
module cp0_reg_timer (
    input  logic        clk,
    input  logic        rst,
    input  logic        i_count_we,
    input  logic        i_compare_we,
    input  logic [31:0] i_wdata,
    output logic [31:0] o_count,
    output logic [31:0] o_compare,
    output logic        o_timer_int
);

    logic [31:0] r_count;
    logic [31:0] r_compare;
    logic        r_timer_int;

    // Free-running counter; a software write replaces the increment
    always_ff @(posedge clk or negedge rst) begin
        if (!rst)            r_count <= '0;
        else if (i_count_we) r_count <= i_wdata;
        else                 r_count <= r_count + 32'd1;
    end

    // Compare register, software-written only
    always_ff @(posedge clk or negedge rst) begin
        if (!rst)              r_compare <= '0;
        else if (i_compare_we) r_compare <= i_wdata;
    end

    // Sticky interrupt on a nonzero match; a Compare write clears it and beats a same-edge match
    always_ff @(posedge clk or negedge rst) begin
        if (!rst)
            r_timer_int <= 1'b0;
        else if (i_compare_we)
            r_timer_int <= 1'b0;
        else if ((r_compare != '0) && (r_count == r_compare))
            r_timer_int <= 1'b1;
    end

    assign o_count     = r_count;
    assign o_compare   = r_compare;
    assign o_timer_int = r_timer_int;

endmodule

// File: rtl/cp0_reg.sv
// MIPS32 CP0 register file: Count/Compare (in cp0_reg_timer), Status, Cause,
// EPC and read-only PRId/Config, plus exception state capture.
module cp0_reg
    import cp0_reg_pkg::*;
#(
    parameter logic [31:0] PRID_VAL   = 32'h004c_0102,
    parameter logic [31:0] CONFIG_VAL = 32'h0000_8000
) (
    input  logic             clk,
    input  logic             rst,
    cp0_reg_if.slave         bus,
    input  logic [5:0]       int_i,
    output logic [31:0]      count_o,
    output logic [31:0]      compare_o,
    output logic [31:0]      status_o,
    output logic [31:0]      cause_o,
    output logic [31:0]      epc_o,
    output logic [31:0]      config_o,
    output logic [31:0]      prid_o,
    output logic             timer_int_o
);

    logic [31:0] r_status;
    logic [31:0] r_cause;
    logic [31:0] r_epc;

    logic        w_count_we;
    logic        w_compare_we;
    exc_dec_t    w_exc;
    logic [31:0] w_epc_next;

    assign w_count_we   = bus.we_i && (bus.waddr_i == CP0_REG_COUNT);
    assign w_compare_we = bus.we_i && (bus.waddr_i == CP0_REG_COMPARE);
    assign w_exc        = exc_decode(bus.excepttype_i);
    assign w_epc_next   = bus.is_in_delayslot_i ? (bus.current_inst_addr_i - 32'd4)
                                                : bus.current_inst_addr_i;

    cp0_reg_timer u_timer (
        .clk          (clk),
        .rst          (rst),
        .i_count_we   (w_count_we),
        .i_compare_we (w_compare_we),
        .i_wdata      (bus.data_i),
        .o_count      (count_o),
        .o_compare    (compare_o),
        .o_timer_int  (timer_int_o)
    );

    // Status/Cause/EPC: exception capture takes priority over the MTC0 write, which is then dropped
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_status <= STATUS_RST;
            r_cause  <= CAUSE_RST;
            r_epc    <= '0;
        end else begin
            r_cause[15:10] <= int_i;
            case (w_exc.kind)
                EXC_K_INT: begin
                    r_epc        <= w_epc_next;
                    r_cause[31]  <= bus.is_in_delayslot_i;
                    r_status[1]  <= 1'b1;
                    r_cause[6:2] <= w_exc.exccode;
                end
                EXC_K_SYNC: begin
                    if (!r_status[1]) begin
                        r_epc       <= w_epc_next;
                        r_cause[31] <= bus.is_in_delayslot_i;
                    end
                    r_status[1]  <= 1'b1;
                    r_cause[6:2] <= w_exc.exccode;
                end
                EXC_K_ERET: begin
                    r_status[1] <= 1'b0;
                end
                EXC_K_OTHER: begin
                end
                default: begin
                    if (bus.we_i) begin
                        case (bus.waddr_i)
                            CP0_REG_STATUS: r_status <= bus.data_i;
                            CP0_REG_EPC:    r_epc    <= bus.data_i;
                            CP0_REG_CAUSE: begin
                                r_cause[9:8] <= bus.data_i[9:8];
                                r_cause[22]  <= bus.data_i[22];
                                r_cause[23]  <= bus.data_i[23];
                            end
                            default: begin
                            end
                        endcase
                    end
                end
            endcase
        end
    end

    // MFC0 read mux of registered values, no write bypass
    always_comb begin
        bus.data_o = '0;
        case (bus.raddr_i)
            CP0_REG_COUNT:   bus.data_o = count_o;
            CP0_REG_COMPARE: bus.data_o = compare_o;
            CP0_REG_STATUS:  bus.data_o = r_status;
            CP0_REG_CAUSE:   bus.data_o = r_cause;
            CP0_REG_EPC:     bus.data_o = r_epc;
            CP0_REG_PRID:    bus.data_o = PRID_VAL;
            CP0_REG_CONFIG:  bus.data_o = CONFIG_VAL;
            default:         bus.data_o = '0;
        endcase
    end

    assign status_o = r_status;
    assign cause_o  = r_cause;
    assign epc_o    = r_epc;
    assign prid_o   = PRID_VAL;
    assign config_o = CONFIG_VAL;

endmodule
